// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared encodings and access helpers for the data-memory
//               responder (access sizes, FSM states, lane/extend functions).
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Access size encodings carried on size_i
  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  // Responder FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Wait-state counter width (supports 0..15 extra cycles)
  localparam int unsigned WAIT_W = 4;

  // An access is rejected for an illegal size, misalignment or a word index
  // beyond the RAM depth.
  function automatic logic access_err(input logic [1:0]  size,
                                      input logic [31:0] addr,
                                      input int unsigned depth_words);
    logic bad_align;
    case (size)
      SIZE_BYTE: bad_align = 1'b0;
      SIZE_HALF: bad_align = addr[0];
      SIZE_WORD: bad_align = |addr[1:0];
      default:   bad_align = 1'b1;
    endcase
    return bad_align | ({2'b00, addr[31:2]} >= depth_words);
  endfunction

  // Byte-enable pattern for a store of the given size at the given offset
  function automatic logic [3:0] byte_en(input logic [1:0] size,
                                         input logic [1:0] lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << lo;
      SIZE_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default:   return 4'b1111;
    endcase
  endfunction

  // Store data replicated across lanes so the enabled lanes see the low bits
  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

  // Select byte/half from the RAM word and sign- or zero-extend it
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  lo,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lo, 3'b000});
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: return uns ? {24'b0, b} : {{24{b[7]}}, b};
      SIZE_HALF: return uns ? {16'b0, h} : {{16{h[15]}}, h};
      default:   return word;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_byte_ram
// Description : Single-port DEPTH_WORDS x 32 synchronous RAM with four byte
//               enables and a registered read port (block-RAM inferable).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_byte_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = 10
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [3:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] rdata_q;

  // Byte-masked write and registered read; contents are never reset
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
      rdata_q <= mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/data_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_slave
// Description : Data-memory responder: accepts load/store requests, applies
//               optional wait states, accesses the byte RAM and returns
//               aligned, extended load data with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_slave
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  output logic        ready_o,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT =
    (WAIT_CYCLES == 0) ? '0 : WAIT_W'(WAIT_CYCLES - 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic        accept;
  logic        acc_fire, acc_we, acc_err;
  logic [1:0]  acc_size;
  logic [31:0] acc_addr, acc_wdata;
  logic        ram_en;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata;
  logic        resp_err;

  assign accept = req_i && ready_o;

  // Choose what reaches the RAM: with no wait states the access happens on the
  // accepting edge itself, so the live request is used; otherwise the latched
  // request is used on the edge that leaves WAIT.
  always_comb begin
    if (WAIT_CYCLES == 0) begin
      acc_fire  = accept;
      acc_we    = we_i;
      acc_size  = size_i;
      acc_addr  = addr_i;
      acc_wdata = wdata_i;
    end else begin
      acc_fire  = (state_q == ST_WAIT) && (cnt_q == '0);
      acc_we    = we_q;
      acc_size  = size_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
    end
    acc_err   = access_err(acc_size, acc_addr, DEPTH_WORDS);
    ram_en    = acc_fire && !rst;
    ram_be    = (ram_en && acc_we && !acc_err) ? byte_en(acc_size, acc_addr[1:0]) : 4'b0000;
    ram_wdata = lane_data(acc_size, acc_wdata);
  end

  dmem_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .en_i    (ram_en),
    .be_i    (ram_be),
    .addr_i  (acc_addr[AW+1:2]),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // State, wait counter and request latch registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      size_q  <= SIZE_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // Next state: accept in IDLE/RESP, count down wait states, then respond
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (accept) begin
          we_d    = we_i;
          size_d  = size_i;
          uns_d   = unsigned_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          cnt_d   = WAIT_INIT;
          state_d = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        end else if (state_q == ST_RESP) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: handshake from state, response fields from the latched request
  always_comb begin
    resp_err = access_err(size_q, addr_q, DEPTH_WORDS);
    ready_o  = (state_q != ST_WAIT);
    rvalid_o = (state_q == ST_RESP);
    err_o    = rvalid_o && resp_err;
    rdata_o  = '0;
    if (rvalid_o && !resp_err && !we_q)
      rdata_o = load_extend(size_q, uns_q, addr_q[1:0], ram_rdata);
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_slave
// Description : Self-checking bench for data_mem_slave; one instance with no
//               wait states and one with three, scoreboarded responses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_slave;
  import dmem_pkg::*;

  localparam int unsigned DEPTH = 256;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e0, e3;

  // Instance with no wait states
  logic        rst0, req0, we0, uns0, ready0, rvalid0, err0;
  logic [1:0]  size0;
  logic [31:0] addr0, wdata0, rdata0;

  // Instance with three wait states
  logic        rst3, req3, we3, uns3, ready3, rvalid3, err3;
  logic [1:0]  size3;
  logic [31:0] addr3, wdata3, rdata3;

  data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst0), .req_i(req0), .ready_o(ready0), .we_i(we0),
    .size_i(size0), .unsigned_i(uns0), .addr_i(addr0), .wdata_i(wdata0),
    .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  data_mem_slave #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst3), .req_i(req3), .ready_o(ready3), .we_i(we3),
    .size_i(size3), .unsigned_i(uns3), .addr_i(addr3), .wdata_i(wdata3),
    .rvalid_o(rvalid3), .rdata_o(rdata3), .err_o(err3)
  );

  // Scoreboard comparators: every response pulse pops one expectation
  always @(negedge clk) begin
    if (rvalid0) begin
      checks = checks + 1;
      if (q0.size() == 0) begin
        errors = errors + 1;
        $display("FAIL dut0_unexpected_rvalid: got rdata=%h err=%b, expected no response", rdata0, err0);
      end else begin
        e0 = q0.pop_front();
        if ({rdata0, err0} !== {e0.rd, e0.err}) begin
          errors = errors + 1;
          $display("FAIL dut0_response: got rdata=%h err=%b, expected rdata=%h err=%b", rdata0, err0, e0.rd, e0.err);
        end
      end
    end
    if (rvalid3) begin
      checks = checks + 1;
      if (q3.size() == 0) begin
        errors = errors + 1;
        $display("FAIL dut3_unexpected_rvalid: got rdata=%h err=%b, expected no response", rdata3, err3);
      end else begin
        e3 = q3.pop_front();
        if ({rdata3, err3} !== {e3.rd, e3.err}) begin
          errors = errors + 1;
          $display("FAIL dut3_response: got rdata=%h err=%b, expected rdata=%h err=%b", rdata3, err3, e3.rd, e3.err);
        end
      end
    end
  end

  // One request to the zero-wait instance; accepted on the next edge
  task automatic issue0(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e);
    req0 = 1'b1; we0 = we; size0 = sz; uns0 = uns; addr0 = a; wdata0 = wd;
    q0.push_back({rd, e});
    checks = checks + 1;
    if (ready0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL dut0_ready_at_issue: got %b, expected 1", ready0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
  endtask

  // One request to the wait-state instance, held until accepted
  task automatic issue3(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rd, input logic e);
    logic acc;
    acc = 1'b0;
    req3 = 1'b1; we3 = we; size3 = sz; uns3 = uns; addr3 = a; wdata3 = wd;
    q3.push_back({rd, e});
    for (int i = 0; i < 40; i++) begin
      acc = ready3;
      @(posedge clk); #1;
      if (acc) break;
    end
    req3 = 1'b0;
    checks = checks + 1;
    if (!acc) begin
      errors = errors + 1;
      $display("FAIL dut3_accept_timeout: got no acceptance in 40 cycles, expected acceptance");
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && (q0.size() != 0 || q3.size() != 0); i++) @(posedge clk);
    #1;
    checks = checks + 1;
    if (q0.size() != 0 || q3.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d/%0d outstanding responses, expected 0/0", q0.size(), q3.size());
    end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst3 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks = checks + 1;
    if ({ready0, rvalid0, rdata0, err0} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset_dut0: got ready=%b rvalid=%b rdata=%h err=%b, expected 1 0 00000000 0", ready0, rvalid0, rdata0, err0);
    end
    checks = checks + 1;
    if ({ready3, rvalid3, rdata3, err3} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      errors = errors + 1;
      $display("FAIL reset_dut3: got ready=%b rvalid=%b rdata=%h err=%b, expected 1 0 00000000 0", ready3, rvalid3, rdata3, err3);
    end
    rst0 = 1'b0; rst3 = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    req0 = 1'b1; we0 = 1'b1; size0 = SIZE_WORD; uns0 = 1'b0; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
    q0.push_back({32'h0, 1'b0});
    @(posedge clk); #1;
    we0 = 1'b0; wdata0 = 32'h0;
    q0.push_back({32'hDEADBEEF, 1'b0});
    @(negedge clk);
    checks = checks + 1;
    if (rvalid0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL b2b_first_pulse: got rvalid=%b, expected 1", rvalid0);
    end
    @(posedge clk); #1;
    req0 = 1'b0;
    @(negedge clk);
    checks = checks + 1;
    if (rvalid0 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL b2b_second_pulse: got rvalid=%b, expected 1", rvalid0);
    end
    @(negedge clk);
    checks = checks + 1;
    if (rvalid0 !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL b2b_pulse_end: got rvalid=%b, expected 0", rvalid0);
    end
  endtask

  task automatic test_subword();
    issue0(1'b1, SIZE_WORD, 1'b0, 32'h20, 32'h0,        32'h0,        1'b0);
    issue0(1'b1, SIZE_BYTE, 1'b0, 32'h21, 32'h12345680, 32'h0,        1'b0);
    issue0(1'b0, SIZE_BYTE, 1'b0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0);
    issue0(1'b0, SIZE_BYTE, 1'b1, 32'h21, 32'h0,        32'h00000080, 1'b0);
    issue0(1'b0, SIZE_WORD, 1'b0, 32'h20, 32'h0,        32'h00008000, 1'b0);
  endtask

  task automatic test_half();
    issue0(1'b1, SIZE_WORD, 1'b0, 32'h30, 32'h0,        32'h0,        1'b0);
    issue0(1'b1, SIZE_HALF, 1'b0, 32'h32, 32'h1234F00D, 32'h0,        1'b0);
    issue0(1'b0, SIZE_WORD, 1'b0, 32'h30, 32'h0,        32'hF00D0000, 1'b0);
    issue0(1'b0, SIZE_HALF, 1'b0, 32'h32, 32'h0,        32'hFFFFF00D, 1'b0);
    issue0(1'b0, SIZE_HALF, 1'b1, 32'h32, 32'h0,        32'h0000F00D, 1'b0);
  endtask

  task automatic test_errors();
    issue0(1'b0, SIZE_WORD,    1'b0, 32'h13,      32'h0,        32'h0,        1'b1);
    issue0(1'b1, SIZE_WORD,    1'b0, 32'h14,      32'hCAFEBABE, 32'h0,        1'b0);
    issue0(1'b1, SIZE_HALF,    1'b0, 32'h15,      32'h00001111, 32'h0,        1'b1);
    issue0(1'b0, SIZE_WORD,    1'b0, 32'h14,      32'h0,        32'hCAFEBABE, 1'b0);
    issue0(1'b1, SIZE_WORD,    1'b0, 32'h0,       32'h0,        32'h0,        1'b0);
    issue0(1'b1, SIZE_WORD,    1'b0, 4 * DEPTH,   32'h55555555, 32'h0,        1'b1);
    issue0(1'b0, SIZE_WORD,    1'b0, 4 * DEPTH,   32'h0,        32'h0,        1'b1);
    issue0(1'b0, SIZE_WORD,    1'b0, 32'h0,       32'h0,        32'h0,        1'b0);
    issue0(1'b1, SIZE_ILLEGAL, 1'b0, 32'h14,      32'h77777777, 32'h0,        1'b1);
    issue0(1'b0, SIZE_ILLEGAL, 1'b0, 32'h14,      32'h0,        32'h0,        1'b1);
    issue0(1'b0, SIZE_WORD,    1'b0, 32'h14,      32'h0,        32'hCAFEBABE, 1'b0);
  endtask

  task automatic test_wait_timing();
    req3 = 1'b1; we3 = 1'b1; size3 = SIZE_WORD; uns3 = 1'b0; addr3 = 32'h50; wdata3 = 32'h11223344;
    q3.push_back({32'h0, 1'b0});
    checks = checks + 1;
    if (ready3 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL wait_ready_before: got %b, expected 1", ready3);
    end
    @(posedge clk); #1;
    we3 = 1'b0; wdata3 = 32'h0;
    q3.push_back({32'h11223344, 1'b0});
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks = checks + 1;
      if ({ready3, rvalid3} !== 2'b00) begin
        errors = errors + 1;
        $display("FAIL wait_cycle_%0d: got ready=%b rvalid=%b, expected 0 0", c, ready3, rvalid3);
      end
    end
    @(negedge clk);
    checks = checks + 1;
    if ({ready3, rvalid3} !== 2'b11) begin
      errors = errors + 1;
      $display("FAIL wait_resp_cycle: got ready=%b rvalid=%b, expected 1 1", ready3, rvalid3);
    end
    @(posedge clk); #1;
    req3 = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks = checks + 1;
      if (rvalid3 !== 1'b0) begin
        errors = errors + 1;
        $display("FAIL held_req_wait_%0d: got rvalid=%b, expected 0", c, rvalid3);
      end
    end
    @(negedge clk);
    checks = checks + 1;
    if (rvalid3 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL held_req_resp: got rvalid=%b, expected 1", rvalid3);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    logic seen;
    seen = 1'b0;
    issue3(1'b1, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    issue3(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    drain();
    req3 = 1'b1; we3 = 1'b1; size3 = SIZE_WORD; addr3 = 32'h40; wdata3 = 32'hAAAA5555;
    @(posedge clk); #1;
    req3 = 1'b0; we3 = 1'b0;
    @(posedge clk); #1;
    rst3 = 1'b1;
    @(posedge clk); #1;
    rst3 = 1'b0;
    checks = checks + 1;
    if (ready3 !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL rst_mid_wait_ready: got %b, expected 1", ready3);
    end
    repeat (8) begin
      @(negedge clk);
      if (rvalid3 === 1'b1) seen = 1'b1;
    end
    checks = checks + 1;
    if (seen) begin
      errors = errors + 1;
      $display("FAIL rst_mid_wait_no_resp: got rvalid pulse, expected none");
    end
    @(posedge clk); #1;
    issue3(1'b0, SIZE_WORD, 1'b0, 32'h40, 32'h0, 32'h0, 1'b0);
    drain();
  endtask

  initial begin
    rst0 = 1'b1; req0 = 1'b0; we0 = 1'b0; size0 = SIZE_WORD; uns0 = 1'b0; addr0 = '0; wdata0 = '0;
    rst3 = 1'b1; req3 = 1'b0; we3 = 1'b0; size3 = SIZE_WORD; uns3 = 1'b0; addr3 = '0; wdata3 = '0;
    test_reset();
    test_back_to_back();
    test_subword();
    test_half();
    test_errors();
    drain();
    test_wait_timing();
    drain();
    test_reset_mid_wait();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
